// File: rtl/i2si_pkg.sv
// Shared I2S BIST definitions: checker state encoding, default sample width and
// the single ramp rule used by both i2si_bist_gen and i2si_bist_chk.
package i2si_pkg;

  localparam int DW_DEFAULT = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    VERIFY = 2'd2,
    LOCKED = 2'd3
  } bist_state_e;

  // Operands are zero-extended sample values. The extra carry bit keeps the
  // limit compare exact, and the result never exceeds start or limit, so the
  // caller can truncate it back to its sample width.
  function automatic logic [31:0] ramp_next(input logic [31:0] cur,
                                            input logic [31:0] inc,
                                            input logic [31:0] start,
                                            input logic [31:0] limit);
    logic [32:0] nxt;
    nxt = {1'b0, cur} + {1'b0, inc};
    if (nxt > {1'b0, limit}) begin
      ramp_next = start;
    end else begin
      ramp_next = nxt[31:0];
    end
  endfunction

endpackage

// File: rtl/i2si_bist_exp.sv
// Expected-sample register for the I2S BIST checker. load selects start_val,
// adv steps one ramp value, and both together seed to ramp(start_val).
module i2si_bist_exp
  import i2si_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          adv,
  input  logic [DW-1:0] start_val,
  input  logic [7:0]    inc,
  input  logic [DW-1:0] up_limit,
  output logic [DW-1:0] exp_val
);

  logic [DW-1:0] exp_d;
  logic [DW-1:0] exp_q;
  logic [DW-1:0] base_s;

  // Next expected value: choose a base, then optionally step it along the ramp
  always_comb begin
    base_s = load ? start_val : exp_q;
    if (adv) begin
      exp_d = DW'(ramp_next(32'(base_s), 32'(inc), 32'(start_val), 32'(up_limit)));
    end else begin
      exp_d = base_s;
    end
  end

  // Expected-value register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q <= '0;
    end else begin
      exp_q <= exp_d;
    end
  end

  assign exp_val = exp_q;

endmodule

// File: rtl/i2si_bist_chk.sv
// Receive-side BIST checker for the I2S input path: locks onto the ramp from
// i2si_bist_gen and counts checked samples and mismatches.
// Define I2SI_BIST_CHK_FIRST_ERR_EN to add first-mismatch capture outputs.
module i2si_bist_chk
  import i2si_pkg::*;
#(
  parameter int DW       = DW_DEFAULT,
  parameter int CW       = 16,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rf_bist_chk_en,
  input  logic          rf_bist_clr,
  input  logic [DW-1:0] rf_bist_start_val,
  input  logic [7:0]    rf_bist_inc,
  input  logic [DW-1:0] rf_bist_up_limit,
  input  logic [DW-1:0] i2si_bist_in_data,
  input  logic          i2si_bist_in_vld,
  output logic          i2si_bist_chk_locked,
  output logic          i2si_bist_chk_fail,
  output logic [CW-1:0] i2si_bist_chk_smp_cnt,
`ifdef I2SI_BIST_CHK_FIRST_ERR_EN
  output logic [DW-1:0] i2si_bist_chk_first_got,
  output logic [DW-1:0] i2si_bist_chk_first_exp,
`endif
  output logic [CW-1:0] i2si_bist_chk_err_cnt
);

  localparam int            RW      = $clog2(((LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT) + 1);
  localparam logic [RW-1:0] LOCK_V  = RW'(LOCK_CNT);
  localparam logic [RW-1:0] LOSS_V  = RW'(LOSS_CNT);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  bist_state_e   state_d, state_q;
  logic [RW-1:0] run_d, run_q, miss_d, miss_q;
  logic [CW-1:0] smp_d, smp_q, err_d, err_q;
  logic          fail_d, fail_q, locked_d, locked_q;
  logic          exp_load_s, exp_adv_s, hit_start_s, hit_exp_s;
  logic [DW-1:0] exp_s;

`ifdef I2SI_BIST_CHK_FIRST_ERR_EN
  logic [DW-1:0] first_got_d, first_got_q, first_exp_d, first_exp_q;
  logic          first_seen_d, first_seen_q;
`endif

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CW'(1);
  endfunction

  assign hit_start_s = (i2si_bist_in_data == rf_bist_start_val);
  assign hit_exp_s   = (i2si_bist_in_data == exp_s);

  i2si_bist_exp #(.DW(DW)) u_exp (
    .clk       (clk),
    .rst       (rst),
    .load      (exp_load_s),
    .adv       (exp_adv_s),
    .start_val (rf_bist_start_val),
    .inc       (rf_bist_inc),
    .up_limit  (rf_bist_up_limit),
    .exp_val   (exp_s)
  );

  // Lock sequencing, counter updates and expected-register control
  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    miss_d     = miss_q;
    smp_d      = smp_q;
    err_d      = err_q;
    fail_d     = fail_q;
    exp_load_s = 1'b0;
    exp_adv_s  = 1'b0;
`ifdef I2SI_BIST_CHK_FIRST_ERR_EN
    first_got_d  = first_got_q;
    first_exp_d  = first_exp_q;
    first_seen_d = first_seen_q;
`endif
    if (!rf_bist_chk_en) begin
      state_d    = IDLE;
      run_d      = '0;
      miss_d     = '0;
      exp_load_s = 1'b1;
    end else begin
      case (state_q)
        // An enabled IDLE hunts exactly like SEARCH so no sample is lost
        IDLE, SEARCH: begin
          state_d    = SEARCH;
          exp_load_s = 1'b1;
          if (i2si_bist_in_vld && hit_start_s) begin
            exp_adv_s = 1'b1;
            run_d     = RW'(1);
            state_d   = (LOCK_V == RW'(1)) ? LOCKED : VERIFY;
          end else begin
            run_d = '0;
          end
        end
        VERIFY: begin
          if (!i2si_bist_in_vld) begin
            state_d = VERIFY;
          end else if (hit_exp_s) begin
            exp_adv_s = 1'b1;
            run_d     = run_q + RW'(1);
            if (run_d == LOCK_V) begin
              state_d = LOCKED;
              miss_d  = '0;
            end else begin
              state_d = VERIFY;
            end
          end else if (hit_start_s) begin
            exp_load_s = 1'b1;
            exp_adv_s  = 1'b1;
            run_d      = RW'(1);
            state_d    = VERIFY;
          end else begin
            exp_load_s = 1'b1;
            run_d      = '0;
            state_d    = SEARCH;
          end
        end
        LOCKED: begin
          if (i2si_bist_in_vld) begin
            smp_d = sat_inc(smp_q);
            if (hit_exp_s) begin
              miss_d = '0;
            end else begin
              err_d  = sat_inc(err_q);
              fail_d = 1'b1;
              miss_d = miss_q + RW'(1);
`ifdef I2SI_BIST_CHK_FIRST_ERR_EN
              if (!first_seen_q) begin
                first_got_d  = i2si_bist_in_data;
                first_exp_d  = exp_s;
                first_seen_d = 1'b1;
              end else begin
                first_seen_d = 1'b1;
              end
`endif
            end
            // Slip-free model: expected value steps on every sample until lock is lost
            if (miss_d == LOSS_V) begin
              state_d    = SEARCH;
              exp_load_s = 1'b1;
              run_d      = '0;
              miss_d     = '0;
            end else begin
              exp_adv_s = 1'b1;
            end
          end else begin
            state_d = LOCKED;
          end
        end
        default: begin
          state_d    = IDLE;
          exp_load_s = 1'b1;
        end
      endcase
    end
    smp_d    = rf_bist_clr ? '0   : smp_d;
    err_d    = rf_bist_clr ? '0   : err_d;
    fail_d   = rf_bist_clr ? 1'b0 : fail_d;
    locked_d = (state_d == LOCKED);
`ifdef I2SI_BIST_CHK_FIRST_ERR_EN
    first_got_d  = rf_bist_clr ? '0   : first_got_d;
    first_exp_d  = rf_bist_clr ? '0   : first_exp_d;
    first_seen_d = rf_bist_clr ? 1'b0 : first_seen_d;
`endif
  end

  // State, counter and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      run_q    <= '0;
      miss_q   <= '0;
      smp_q    <= '0;
      err_q    <= '0;
      fail_q   <= 1'b0;
      locked_q <= 1'b0;
`ifdef I2SI_BIST_CHK_FIRST_ERR_EN
      first_got_q  <= '0;
      first_exp_q  <= '0;
      first_seen_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      miss_q   <= miss_d;
      smp_q    <= smp_d;
      err_q    <= err_d;
      fail_q   <= fail_d;
      locked_q <= locked_d;
`ifdef I2SI_BIST_CHK_FIRST_ERR_EN
      first_got_q  <= first_got_d;
      first_exp_q  <= first_exp_d;
      first_seen_q <= first_seen_d;
`endif
    end
  end

  assign i2si_bist_chk_locked  = locked_q;
  assign i2si_bist_chk_fail    = fail_q;
  assign i2si_bist_chk_smp_cnt = smp_q;
  assign i2si_bist_chk_err_cnt = err_q;
`ifdef I2SI_BIST_CHK_FIRST_ERR_EN
  assign i2si_bist_chk_first_got = first_got_q;
  assign i2si_bist_chk_first_exp = first_exp_q;
`endif

endmodule

// File: tb/tb_i2si_bist_chk.sv
// Scoreboard bench for i2si_bist_chk: a per-sample reference model pushes the
// expected register-file view, and a monitor compares it one cycle after each sample.
module tb_i2si_bist_chk;

  localparam int DW       = 12;
  localparam int CW       = 8;   // narrow counters so saturation is reachable quickly
  localparam int LOCK_CNT = 4;
  localparam int LOSS_CNT = 8;
  localparam int CMAX     = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, en, clr, vld;
  logic [DW-1:0] start_val, up_limit, data;
  logic [7:0]    inc;
  logic          locked, fail;
  logic [CW-1:0] smp_cnt, err_cnt;

  typedef struct {bit lk; bit fl; int smp; int err;} resp_t;
  resp_t sbq[$];

  int errors = 0;
  int checks = 0;
  int m_mode, m_run, m_miss, m_exp, m_smp, m_err;  // m_mode: 0 hunting, 1 confirming, 2 locked
  bit m_fail;
  int g;

  i2si_bist_chk #(.DW(DW), .CW(CW), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .rf_bist_chk_en        (en),
    .rf_bist_clr           (clr),
    .rf_bist_start_val     (start_val),
    .rf_bist_inc           (inc),
    .rf_bist_up_limit      (up_limit),
    .i2si_bist_in_data     (data),
    .i2si_bist_in_vld      (vld),
    .i2si_bist_chk_locked  (locked),
    .i2si_bist_chk_fail    (fail),
    .i2si_bist_chk_smp_cnt (smp_cnt),
    .i2si_bist_chk_err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  function automatic int ramp(input int cur);
    int n;
    n = cur + int'(inc);
    return (n > int'(up_limit)) ? int'(start_val) : n;
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_run = 0; m_miss = 0; m_exp = 0;
    m_smp = 0; m_err = 0; m_fail = 1'b0;
  endfunction

  function automatic void model_step(input bit e, input bit v, input int d, input bit c);
    if (!e) begin
      m_mode = 0; m_run = 0; m_miss = 0;
    end else if (v) begin
      if (m_mode == 2) begin
        m_smp = (m_smp < CMAX) ? m_smp + 1 : CMAX;
        if (d != m_exp) begin
          m_err  = (m_err < CMAX) ? m_err + 1 : CMAX;
          m_fail = 1'b1;
          m_miss++;
        end else begin
          m_miss = 0;
        end
        if (m_miss == LOSS_CNT) begin
          m_mode = 0; m_miss = 0; m_run = 0;
        end else begin
          m_exp = ramp(m_exp);
        end
      end else if (m_mode == 1 && d == m_exp) begin
        m_exp = ramp(m_exp);
        m_run++;
        if (m_run == LOCK_CNT) begin
          m_mode = 2; m_miss = 0;
        end
      end else if (d == int'(start_val)) begin
        m_exp = ramp(int'(start_val)); m_run = 1; m_mode = 1;
      end else begin
        m_mode = 0; m_run = 0;
      end
    end
    if (c) begin
      m_smp = 0; m_err = 0; m_fail = 1'b0;
    end
  endfunction

  // One clock of stimulus; the expectation for that cycle is queued when it carries vld or clr
  task automatic step(input bit v, input int d, input bit c);
    resp_t r;
    vld  = v;
    data = DW'(d);
    clr  = c;
    model_step(en, v, d, c);
    if (v || c) begin
      r.lk = (m_mode == 2); r.fl = m_fail; r.smp = m_smp; r.err = m_err;
      sbq.push_back(r);
    end
    @(posedge clk);
    #1;
    vld = 1'b0;
    clr = 1'b0;
  endtask

  task automatic send(input int d, input int gap);
    step(1'b1, d, 1'b0);
    repeat (gap) step(1'b0, 0, 1'b0);
  endtask

  task automatic setup(input int s, input int i, input int l);
    en = 1'b0;
    repeat (2) step(1'b0, 0, 1'b0);
    start_val = DW'(s); inc = 8'(i); up_limit = DW'(l);
    step(1'b0, 0, 1'b1);
    en = 1'b1;
    step(1'b0, 0, 1'b0);
    g = s;
  endtask

  task automatic send_ramp(input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      send(g, gap);
      g = ramp(g);
    end
  endtask

  task automatic check_out(input string tag, input int lk, input int fl, input int smp, input int err);
    check({tag, "_locked"}, int'(locked), lk);
    check({tag, "_fail"}, int'(fail), fl);
    check({tag, "_smp"}, int'(smp_cnt), smp);
    check({tag, "_err"}, int'(err_cnt), err);
  endtask

  // Monitor: outputs reflect a vld/clr cycle at the following falling edge
  initial begin : monitor
    resp_t e;
    bit    p;
    forever begin
      @(posedge clk);
      p = vld | clr;
      @(negedge clk);
      if (p) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_underflow: got an output event, want a queued expectation");
        end else begin
          e = sbq.pop_front();
          check("sb_locked", int'(locked), int'(e.lk));
          check("sb_fail", int'(fail), int'(e.fl));
          check("sb_smp", int'(smp_cnt), e.smp);
          check("sb_err", int'(err_cnt), e.err);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish, want finish within time budget");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int rs, ri, rl, d;
    bit c, drop;
    rst = 1'b1; en = 1'b0; clr = 1'b0; vld = 1'b0; data = '0;
    start_val = DW'(1); inc = 8'd1; up_limit = DW'(25);
    model_reset();
    #1 rst = 1'b0;
    #2 check_out("reset", 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Nominal lock with wrap 0x019 -> 0x001
    setup(12'h001, 1, 12'h019);
    send_ramp(30, 3);
    check_out("nominal", 1, 0, 26, 0);

    // Single corruption of 0x00A
    for (int k = 0; k < 10; k++) begin
      send((g == 12'h00A) ? 12'h0FF : g, 3);
      g = ramp(g);
    end
    check_out("corrupt", 1, 1, 36, 1);

    // Loss of lock after 8 consecutive misses, then relock with fail held
    step(1'b0, 0, 1'b1);
    for (int k = 0; k < LOSS_CNT; k++) send(12'h000, 3);
    check_out("loss", 0, 1, 8, 8);
    g = 12'h001;
    send_ramp(4, 3);
    check_out("relock", 1, 1, 8, 8);

    // Mid-stream start
    setup(12'h001, 1, 12'h019);
    g = 12'h010;
    send_ramp(20, 1);
    check_out("midstream", 1, 0, 6, 0);

    // inc = 0 constant stream
    setup(12'h001, 0, 12'h019);
    send_ramp(8, 1);
    check_out("inc0", 1, 0, 4, 0);

    // 0x0FF, 0x17F, 0x0FF ... with inc 0x80 and limit 0x17F
    setup(12'h0FF, 8'h80, 12'h17F);
    for (int k = 0; k < 8; k++) send((k % 2 == 0) ? 12'h0FF : 12'h17F, 1);
    check_out("wrap80", 1, 0, 4, 0);

    // limit below start wraps on every step
    setup(12'h050, 3, 12'h010);
    for (int k = 0; k < 6; k++) send(12'h050, 0);
    check_out("lowlimit", 1, 0, 2, 0);

    // clr in the same cycle as a mismatch wins
    setup(12'h001, 1, 12'h019);
    send_ramp(6, 1);
    step(1'b1, 12'h0FF, 1'b1);
    step(1'b0, 0, 1'b0);
    check_out("clr_mismatch", 1, 0, 0, 0);

    // Randomised streams with corruption, restarts, enable drops and clears
    for (int run = 0; run < 6; run++) begin
      rs = $urandom_range(0, 4095);
      ri = $urandom_range(0, 255);
      rl = ($urandom_range(0, 9) < 7) ? rs + $urandom_range(0, 600) : $urandom_range(0, 4095);
      if (rl > 4095) rl = 4095;
      setup(rs, ri, rl);
      for (int k = 0; k < 60; k++) begin
        if ($urandom_range(0, 99) < 4) g = rs;
        d    = ($urandom_range(0, 99) < 10) ? $urandom_range(0, 4095) : g;
        c    = ($urandom_range(0, 99) < 3);
        drop = ($urandom_range(0, 99) < 3);
        en   = !drop;
        step(1'b1, d, c);
        en   = 1'b1;
        g    = ramp(g);
        repeat ($urandom_range(0, 3)) step(1'b0, 0, 1'b0);
      end
    end

    // Counter saturation: repeated lock / 8-miss loss cycles
    setup(12'h001, 1, 12'h019);
    for (int r = 0; r < 36; r++) begin
      g = 12'h001;
      send_ramp(4, 0);
      for (int k = 0; k < LOSS_CNT; k++) send(12'h000, 0);
    end
    check_out("saturate", 0, 1, CMAX, CMAX);

    // Asynchronous reset while locked, then relock
    setup(12'h001, 1, 12'h019);
    send_ramp(6, 1);
    step(1'b0, 0, 1'b0);
    #2 rst = 1'b0;
    #1 check_out("async_rst", 0, 0, 0, 0);
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    g = 12'h001;
    send_ramp(6, 1);
    check_out("post_rst", 1, 0, 2, 0);

    repeat (3) step(1'b0, 0, 1'b0);
    if (sbq.size() != 0) begin
      checks++; errors++;
      $display("FAIL sb_leftover: got %0d pending expectations, want 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
